// File: rtl/controlador_detector.sv
`default_nettype none
// ============================================================================
// Module      : controlador_detector
// Description : Sequencer for a serial pattern-detection engine. Latches a
//               parallel data word and a pattern on a start handshake, shifts
//               the word MSB-first through a PAT_W-bit detection window and
//               pulses y on every (overlapping) pattern occurrence. The total
//               match count is reported in contagem when done pulses.
//               Optional feature macro: DETECTOR_MASK_EN (adds the mascara
//               input; zero bits in mascara are don't-care in the compare).
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_detector #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] dado,
    input  logic [PAT_W-1:0]  padrao,
`ifdef DETECTOR_MASK_EN
    input  logic [PAT_W-1:0]  mascara,
`endif
    output logic              busy,
    output logic              done,
    output logic              bit_atual,
    output logic              y,
    output logic [CNT_W-1:0]  contagem
);

    // Bit index must reach WORD_W-1; keep at least one bit for WORD_W == 1.
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [IDX_W-1:0] c_PRIMEIRO = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] c_ULTIMO   = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] c_IDX_UM   = IDX_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_UM   = CNT_W'(1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DESLOCA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t           r_estado;
    logic [WORD_W-1:0] r_dado;
    logic [PAT_W-1:0]  r_padrao;
    logic [PAT_W-1:0]  r_janela;
    logic [IDX_W-1:0]  r_indice;
`ifdef DETECTOR_MASK_EN
    logic [PAT_W-1:0]  r_mascara;
`endif

    logic              w_bit;
    logic [PAT_W-1:0]  w_janela_prox;
    logic              w_igual;
    logic              w_casa;

    // The latched word is shifted left, so its MSB is always the next bit.
    assign w_bit         = r_dado[WORD_W-1];
    // Window as it will look after this edge: oldest bit drops off the top.
    assign w_janela_prox = (r_janela << 1) | PAT_W'(w_bit);

`ifdef DETECTOR_MASK_EN
    assign w_igual = (((w_janela_prox ^ r_padrao) & r_mascara) == '0);
`else
    assign w_igual = (w_janela_prox == r_padrao);
`endif

    // A match only counts once the window holds PAT_W real data bits.
    assign w_casa = (r_indice >= c_PRIMEIRO) && w_igual;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_dado    <= '0;
            r_padrao  <= '0;
            r_janela  <= '0;
            r_indice  <= '0;
`ifdef DETECTOR_MASK_EN
            r_mascara <= '0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_atual <= 1'b0;
            y         <= 1'b0;
            contagem  <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    y    <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_dado    <= dado;
                        r_padrao  <= padrao;
`ifdef DETECTOR_MASK_EN
                        r_mascara <= mascara;
`endif
                        r_janela  <= '0;
                        r_indice  <= '0;
                        contagem  <= '0;
                        busy      <= 1'b1;
                        r_estado  <= DESLOCA;
                    end
                end

                DESLOCA: begin
                    r_dado    <= r_dado << 1;
                    r_janela  <= w_janela_prox;
                    bit_atual <= w_bit;
                    y         <= w_casa;
                    r_indice  <= r_indice + c_IDX_UM;
                    if (w_casa) begin
                        contagem <= contagem + c_CNT_UM;
                    end
                    // Last bit: leave shifting and flag completion on the same edge.
                    if (r_indice == c_ULTIMO) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_estado <= FIM;
                    end
                end

                FIM: begin
                    done     <= 1'b0;
                    y        <= 1'b0;
                    r_estado <= OCIOSO;
                end

                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_detector
// Description : Self-checking bench for controlador_detector (default build,
//               mascara feature disabled). Expected values come from a
//               reference model that slides a PAT_W-bit view over the data
//               word with plain shifts and counts equal positions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_detector;

    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [WORD_W-1:0] dado;
    logic [PAT_W-1:0]  padrao;
    logic              busy;
    logic              done;
    logic              bit_atual;
    logic              y;
    logic [CNT_W-1:0]  contagem;

    int n_checks = 0;
    int n_fail   = 0;

    controlador_detector #(
        .WORD_W (WORD_W),
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dado      (dado),
        .padrao    (padrao),
        .busy      (busy),
        .done      (done),
        .bit_atual (bit_atual),
        .y         (y),
        .contagem  (contagem)
    );

    always #5 clock = ~clock;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: does the pattern end at bit i (MSB-first order) of word d?
    function automatic bit model_match(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p, input int i);
        logic [WORD_W-1:0] vista;
        if (i < PAT_W - 1) return 1'b0;
        vista = d >> (WORD_W - 1 - i);
        return (vista[PAT_W-1:0] == p);
    endfunction

    // Advance one clock and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full run: start for one cycle (or held), check every shifted bit,
    // the done cycle and the return to idle. Optionally corrupts dado mid-run.
    task automatic run(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p,
                       input bit hold, input string nome, output int cnt);
        cnt    = 0;
        dado   = d;
        padrao = p;
        start  = 1'b1;
        tick();
        chk_value({nome, " busy after start"}, busy, 1);
        chk_value({nome, " contagem cleared"}, contagem, 0);
        if (!hold) start = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            bit exp_y;
            tick();
            exp_y = model_match(d, p, i);
            cnt  += int'(exp_y);
            chk_value($sformatf("%s bit_atual[%0d]", nome, i), bit_atual, d[WORD_W-1-i]);
            chk_value($sformatf("%s y[%0d]", nome, i), y, exp_y);
            chk_value($sformatf("%s contagem[%0d]", nome, i), contagem, cnt);
            chk_value($sformatf("%s busy[%0d]", nome, i), busy, (i < WORD_W - 1));
            chk_value($sformatf("%s done[%0d]", nome, i), done, (i == WORD_W - 1));
            if (hold && i == 5) begin
                dado   = 16'hFFFF;
                padrao = 4'b1111;
            end
        end
        tick();
        chk_value({nome, " done falls"}, done, 0);
        chk_value({nome, " y low after FIM"}, y, 0);
        chk_value({nome, " busy low after FIM"}, busy, 0);
        chk_value({nome, " contagem held"}, contagem, cnt);
    endtask

    initial begin
        int  cnt;
        bit  viu_done;

        reset  = 1'b1;
        start  = 1'b0;
        dado   = '0;
        padrao = '0;
        tick();
        tick();
        chk_value("reset busy", busy, 0);
        chk_value("reset done", done, 0);
        chk_value("reset y", y, 0);
        chk_value("reset bit_atual", bit_atual, 0);
        chk_value("reset contagem", contagem, 0);
        reset = 1'b0;
        tick();

        // Directed scenarios from the specification's worked examples.
        run(16'hDB40, 4'b1101, 1'b0, "db40", cnt);
        chk_value("db40 final count", contagem, 3);
        tick();
        tick();
        chk_value("db40 idle busy", busy, 0);
        chk_value("db40 idle contagem held", contagem, 3);

        run(16'hFFFF, 4'b1111, 1'b0, "ffff", cnt);
        chk_value("ffff final count", contagem, 13);

        run(16'h0000, 4'b1010, 1'b0, "zero", cnt);
        chk_value("zero final count", contagem, 0);
        chk_value("zero bit_atual", bit_atual, 0);

        // Start held high all the way, word changed mid-shift.
        run(16'hDB40, 4'b1101, 1'b1, "hold", cnt);
        chk_value("hold final count", contagem, 3);
        // start still high: the edge after idle is the first one that may accept it.
        tick();
        chk_value("hold restart from OCIOSO", busy, 1);
        chk_value("hold restart clears count", contagem, 0);
        start = 1'b0;

        // Abort by reset after bit 7, with reset and start coinciding.
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        dado   = 16'hDB40;
        padrao = 4'b1101;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 7; i++) tick();
        chk_value("pre-abort busy", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk_value("abort busy", busy, 0);
        chk_value("abort done", done, 0);
        chk_value("abort y", y, 0);
        chk_value("abort bit_atual", bit_atual, 0);
        chk_value("abort contagem", contagem, 0);
        tick();
        chk_value("reset beats start", busy, 0);
        reset    = 1'b0;
        start    = 1'b0;
        viu_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) viu_done = 1'b1;
        end
        chk_value("no done after abort", viu_done, 0);
        run(16'hDB40, 4'b1101, 1'b0, "fresh", cnt);
        chk_value("fresh final count", contagem, 3);

        // Randomized runs against the reference model.
        for (int r = 0; r < 30; r++) begin
            logic [WORD_W-1:0] d;
            logic [PAT_W-1:0]  p;
            d = WORD_W'($urandom);
            p = PAT_W'($urandom_range(0, 15));
            if (r % 7 == 3) d = '1;
            if (r % 7 == 5) d = '0;
            run(d, p, 1'b0, $sformatf("rnd%0d", r), cnt);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
